mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit between the EX/MEM pipeline register and the MEM/WB register.
//  Turns the EX/MEM access (address = alu_result_mem) into a req/gnt/rvalid data-memory
//  transaction with byte enables, and aligns/extends load data into read_data_mem.
//  Stalls the pipeline through multi-cycle accesses and flags misaligned/illegal ones.
// PARAMETERS
//  ADDR_W  32  data-memory byte-address width
//  (data path fixed at 32 bits, RV32I)
// PORTS
//  clk             in   1       pipeline clock; all state updates on posedge
//  rst_n           in   1       asynchronous, active-low reset
//  mem_read_mem    in   1       load in MEM stage
//  mem_write_mem   in   1       store in MEM stage
//  funct3_mem      in   3       access size/sign (RV32I load/store funct3)
//  alu_result_mem  in   ADDR_W  effective byte address
//  write_data_mem  in   32      store data (rs2, unaligned)
//  read_data_mem   out  32      aligned, extended load result
//  stall_mem       out  1       freeze IF..EX/MEM while high
//  err_mem         out  1       misaligned/illegal access, valid in DONE
//  dmem_req        out  1       request valid to data memory
//  dmem_we         out  1       1 = write
//  dmem_addr       out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  dmem_wdata      out  32      lane-replicated store data
//  dmem_be         out  4       byte enables
//  dmem_gnt        in   1       memory accepted request this cycle
//  dmem_rvalid     in   1       load data valid this cycle
//  dmem_rdata      in   32      load data word
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; read_data_mem, err_mem, dmem_req, dmem_we, dmem_addr,
//    dmem_wdata, dmem_be all 0. Reset mid-transaction abandons it; any later rvalid/gnt in IDLE ignored.
//  - access = mem_read_mem | mem_write_mem; both high -> treated as store.
//  - stall_mem = access & (state != DONE), combinational.
//  - FSM: IDLE -> REQ on legal access (register req/we/addr/wdata/be, dmem_req=1);
//         IDLE -> DONE on illegal access (no bus activity, err_mem<=1, read_data_mem<=0);
//         REQ: hold all dmem_* stable until dmem_gnt. Store+gnt -> DONE. Load+gnt -> WAIT,
//              or straight to DONE if dmem_rvalid in the same cycle. dmem_req drops on gnt.
//         WAIT: on dmem_rvalid capture aligned data -> DONE; rvalid outside REQ/WAIT ignored.
//         DONE: stall low one cycle, pipeline advances; -> IDLE unconditionally, err_mem<=0.
//  - Latency: legal access with gnt (+rvalid) in first REQ cycle = 2 stall cycles + DONE;
//    illegal = 1 stall cycle + DONE. Back-to-back accesses re-enter REQ from IDLE.
//  - read_data_mem updates only on load capture or error; stable otherwise (MEM/WB samples on
//    negedge, so it must hold from DONE entry until next update).
//  - Legality: funct3 000/100 any addr; 001/101 addr[0]=0; 010 addr[1:0]=0; stores accept only
//    000/001/010; other funct3 illegal.
//  - Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{wd[7:0]}}; SH be=addr[1]?4'b1100:4'b0011,
//    wdata={2{wd[15:0]}}; SW be=4'b1111, wdata=wd. Loads drive be=4'b1111.
//  - Load: shifted = rdata >> (8*addr[1:0]) (offset registered at request);
//    LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
// STRUCTURE
//  - riscv_pkg: F3_B/F3_H/F3_W/F3_BU/F3_HU localparams, lsu_state_t enum {IDLE,REQ,WAIT,DONE}.
//  - Sub-module lsu_align (combinational): legality check, store lane/be generation,
//    load shift/extend; mem_stage_lsu holds FSM and registers.
// TESTING
//  1 SW addr 0x100, wd 0xDEADBEEF, gnt first REQ cycle -> dmem_addr 0x100, be 1111,
//    wdata 0xDEADBEEF, stall 2 cycles, err 0.
//  2 SB addr 0x103, wd 0x000000A5 -> be 1000, wdata 0xA5A5A5A5.
//  3 LH addr 0x102, gnt cycle 1, rvalid 3 cycles later, rdata 0x80FF7F00 -> stall until
//    DONE, read_data 0xFFFF80FF; repeat LHU -> 0x000080FF; LB 0x103 -> 0xFFFFFF80.
//  4 LW addr 0x101 -> dmem_req never high, 1 stall cycle, DONE err_mem 1, read_data 0.
//  5 gnt delayed 4 cycles on SH 0x102 -> req/addr/be 1100/wdata constant every REQ cycle.
//  6 rst_n low in WAIT -> outputs 0 immediately; later rvalid ignored, next LW completes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I load/store funct3 codes and LSU state encoding
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - legality check, store lane/byte-enable generation, load shift/extend
module lsu_align
  import riscv_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  output logic        legal,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    legal = 1'b0;
    case (funct3)
      F3_B:    legal = 1'b1;
      F3_BU:   legal = !is_store;
      F3_H:    legal = !addr_lo[0];
      F3_HU:   legal = !is_store && !addr_lo[0];
      F3_W:    legal = (addr_lo == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Loads always fetch the full word; only stores narrow the byte enables.
  always_comb begin
    be    = 4'b1111;
    wdata = wd;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{wd[7:0]}};
        end
        F3_H: begin
          be    = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata = {2{wd[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = wd;
        end
      endcase
    end
  end

  assign shifted = rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (ld_funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   ld_data = {24'd0, shifted[7:0]};
      F3_HU:   ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: req/gnt/rvalid FSM and result registers
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_mem,
  input  logic              mem_write_mem,
  input  logic [2:0]        funct3_mem,
  input  logic [ADDR_W-1:0] alu_result_mem,
  input  logic [31:0]       write_data_mem,
  output logic [31:0]       read_data_mem,
  output logic              stall_mem,
  output logic              err_mem,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  lsu_state_t  state_q, state_d;
  logic        access, is_store, legal;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ld_data;
  logic [2:0]  ld_f3_q;
  logic [1:0]  off_q;

  assign access    = mem_read_mem | mem_write_mem;
  assign is_store  = mem_write_mem;
  assign stall_mem = access & (state_q != DONE);

  lsu_align u_align (
    .is_store  (is_store),
    .funct3    (funct3_mem),
    .addr_lo   (alu_result_mem[1:0]),
    .wd        (write_data_mem),
    .legal     (legal),
    .be        (be_c),
    .wdata     (wdata_c),
    .ld_funct3 (ld_f3_q),
    .ld_off    (off_q),
    .rdata     (dmem_rdata),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (access) state_d = legal ? REQ : DONE;
      REQ:  if (dmem_gnt) state_d = (dmem_we || dmem_rvalid) ? DONE : WAIT;
      WAIT: if (dmem_rvalid) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus fields are registered once in IDLE and left untouched through REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_mem <= 32'd0;
      err_mem       <= 1'b0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= 32'd0;
      dmem_be       <= 4'd0;
      ld_f3_q       <= 3'd0;
      off_q         <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            if (legal) begin
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= {alu_result_mem[ADDR_W-1:2], 2'b00};
              dmem_wdata <= wdata_c;
              dmem_be    <= be_c;
              ld_f3_q    <= funct3_mem;
              off_q      <= alu_result_mem[1:0];
            end else begin
              err_mem       <= 1'b1;
              read_data_mem <= 32'd0;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (!dmem_we && dmem_rvalid) read_data_mem <= ld_data;
          end
        end
        WAIT: if (dmem_rvalid) read_data_mem <= ld_data;
        DONE: err_mem <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read_mem, mem_write_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] alu_result_mem, write_data_mem, read_data_mem;
  logic        stall_mem, err_mem, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_read_mem   (mem_read_mem),
    .mem_write_mem  (mem_write_mem),
    .funct3_mem     (funct3_mem),
    .alu_result_mem (alu_result_mem),
    .write_data_mem (write_data_mem),
    .read_data_mem  (read_data_mem),
    .stall_mem      (stall_mem),
    .err_mem        (err_mem),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_be        (dmem_be),
    .dmem_gnt       (dmem_gnt),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Presents one access and plays the memory side until DONE (returns at the DONE negedge).
  task automatic run_access(
    input  logic        rd,
    input  logic        wr,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  int          gnt_dly,
    input  int          rv_dly,
    input  logic [31:0] rdat,
    output int          stalls,
    output int          reqs,
    output logic [31:0] a0,
    output logic [3:0]  b0,
    output logic [31:0] w0,
    output bit          stable
  );
    bit granted, done;
    int gc;
    @(posedge clk); #1;
    mem_read_mem   = rd;
    mem_write_mem  = wr;
    funct3_mem     = f3;
    alu_result_mem = addr;
    write_data_mem = wd;
    stalls = 0; reqs = 0; granted = 0; done = 0; gc = 0; stable = 1;
    a0 = '0; b0 = '0; w0 = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      if (!stall_mem) begin
        done = 1;
      end else begin
        stalls++;
        if (dmem_req) begin
          if (reqs == 0) begin
            a0 = dmem_addr; b0 = dmem_be; w0 = dmem_wdata;
          end else if (dmem_addr !== a0 || dmem_be !== b0 || dmem_wdata !== w0) begin
            stable = 0;
          end
          reqs++;
          if (reqs - 1 == gnt_dly) begin
            dmem_gnt = 1'b1;
            granted  = 1;
            if (!dmem_we && rv_dly == 0) begin
              dmem_rvalid = 1'b1;
              dmem_rdata  = rdat;
            end
          end
        end else if (granted) begin
          gc++;
          if (gc == rv_dly) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdat;
          end
        end
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    mem_read_mem  = 1'b0;
    mem_write_mem = 1'b0;
    @(negedge clk);
  endtask

  int          st, rq;
  logic [31:0] a0, w0;
  logic [3:0]  b0;
  bit          stab;

  initial begin
    rst_n = 1'b0;
    mem_read_mem = 1'b0; mem_write_mem = 1'b0; funct3_mem = 3'd0;
    alu_result_mem = '0; write_data_mem = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req",   {31'd0, dmem_req},  32'd0);
    check("rst_we",    {31'd0, dmem_we},   32'd0);
    check("rst_addr",  dmem_addr,          32'd0);
    check("rst_wdata", dmem_wdata,         32'd0);
    check("rst_be",    {28'd0, dmem_be},   32'd0);
    check("rst_rdata", read_data_mem,      32'd0);
    check("rst_err",   {31'd0, err_mem},   32'd0);
    check("rst_stall", {31'd0, stall_mem}, 32'd0);
    rst_n = 1'b1;

    // SW 0x100
    run_access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, st, rq, a0, b0, w0, stab);
    check("sw_addr",   a0, 32'h100);
    check("sw_be",     {28'd0, b0}, 32'hF);
    check("sw_wdata",  w0, 32'hDEADBEEF);
    check("sw_stalls", st, 2);
    check("sw_err",    {31'd0, err_mem}, 32'd0);
    check("sw_req_drop", {31'd0, dmem_req}, 32'd0);

    // SB 0x103, issued back-to-back
    run_access(0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'h0, st, rq, a0, b0, w0, stab);
    check("sb_addr",  a0, 32'h100);
    check("sb_be",    {28'd0, b0}, 32'h8);
    check("sb_wdata", w0, 32'hA5A5A5A5);
    check("sb_stalls", st, 2);

    // LH 0x102 with rvalid three cycles after the grant
    run_access(1, 0, 3'b001, 32'h102, 32'h0, 0, 3, 32'h80FF7F00, st, rq, a0, b0, w0, stab);
    check("lh_be",     {28'd0, b0}, 32'hF);
    check("lh_addr",   a0, 32'h100);
    check("lh_stalls", st, 5);
    check("lh_data",   read_data_mem, 32'hFFFF80FF);
    check("lh_err",    {31'd0, err_mem}, 32'd0);
    run_access(1, 0, 3'b101, 32'h102, 32'h0, 0, 3, 32'h80FF7F00, st, rq, a0, b0, w0, stab);
    check("lhu_data",  read_data_mem, 32'h000080FF);
    run_access(1, 0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF7F00, st, rq, a0, b0, w0, stab);
    check("lb_data",   read_data_mem, 32'hFFFFFF80);
    check("lb_stalls", st, 2);
    run_access(1, 0, 3'b100, 32'h101, 32'h0, 0, 1, 32'h80FF7F00, st, rq, a0, b0, w0, stab);
    check("lbu_data",  read_data_mem, 32'h0000007F);
    run_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 2, 32'h80FF7F00, st, rq, a0, b0, w0, stab);
    check("lw_data",   read_data_mem, 32'h80FF7F00);

    // Misaligned LW: no bus activity, error with zeroed result
    run_access(1, 0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0, st, rq, a0, b0, w0, stab);
    check("mis_reqs",   rq, 0);
    check("mis_stalls", st, 1);
    check("mis_err",    {31'd0, err_mem}, 32'd1);
    check("mis_data",   read_data_mem, 32'd0);
    go_idle();
    check("mis_err_clr", {31'd0, err_mem}, 32'd0);

    // Store with a load-only funct3, and misaligned SH
    run_access(0, 1, 3'b100, 32'h100, 32'h1, 0, 0, 32'h0, st, rq, a0, b0, w0, stab);
    check("sbu_err",  {31'd0, err_mem}, 32'd1);
    check("sbu_reqs", rq, 0);
    run_access(0, 1, 3'b001, 32'h101, 32'h1, 0, 0, 32'h0, st, rq, a0, b0, w0, stab);
    check("sh_mis_err", {31'd0, err_mem}, 32'd1);

    // SH 0x102 with grant held off four cycles
    run_access(0, 1, 3'b001, 32'h102, 32'h00001234, 4, 0, 32'h0, st, rq, a0, b0, w0, stab);
    check("shd_be",     {28'd0, b0}, 32'hC);
    check("shd_wdata",  w0, 32'h12341234);
    check("shd_reqs",   rq, 5);
    check("shd_stable", {31'd0, stab}, 32'd1);
    check("shd_stalls", st, 6);
    check("shd_err",    {31'd0, err_mem}, 32'd0);

    // Load that survives a reset would leave stale data: reset inside WAIT
    run_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hA1B2C3D4, st, rq, a0, b0, w0, stab);
    check("pre_rst_data", read_data_mem, 32'hA1B2C3D4);
    @(posedge clk); #1;
    mem_read_mem = 1'b1; mem_write_mem = 1'b0; funct3_mem = 3'b010; alu_result_mem = 32'h200;
    @(negedge clk);
    @(negedge clk);
    check("rw_req", {31'd0, dmem_req}, 32'd1);
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    check("rw_wait_stall", {31'd0, stall_mem}, 32'd1);
    rst_n = 1'b0;
    mem_read_mem = 1'b0;
    #1;
    check("rw_rst_req",   {31'd0, dmem_req}, 32'd0);
    check("rw_rst_addr",  dmem_addr, 32'd0);
    check("rw_rst_be",    {28'd0, dmem_be}, 32'd0);
    check("rw_rst_rdata", read_data_mem, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("late_rv_data",  read_data_mem, 32'd0);
    check("late_rv_stall", {31'd0, stall_mem}, 32'd0);
    check("late_rv_req",   {31'd0, dmem_req}, 32'd0);
    run_access(1, 0, 3'b010, 32'h204, 32'h0, 1, 1, 32'hCAFEF00D, st, rq, a0, b0, w0, stab);
    check("post_rst_addr", a0, 32'h204);
    check("post_rst_data", read_data_mem, 32'hCAFEF00D);
    check("post_rst_stalls", st, 4);
    go_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
